// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between initiator and dmem_responder
interface dmem_responder_if #(
  parameter int AW = 6,
  parameter int DW = 32
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          err;
  logic          busy;

  modport master (output req, we, addr, wdata, input ready, rdata, err, busy);
  modport slave  (input req, we, addr, wdata, output ready, rdata, err, busy);
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory with fixed wait states
module dmem_responder #(
  parameter int AW    = 6,
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input logic             clk,
  input logic             clr_n,
  dmem_responder_if.slave bus
);
  localparam int          CW      = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          enter_resp;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          acc_ok;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          if (WAIT == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CW'(WAIT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With no wait states the access happens on the acceptance edge, before the latches settle.
  assign acc_we    = (state == ST_IDLE) ? bus.we    : we_q;
  assign acc_addr  = (state == ST_IDLE) ? bus.addr  : addr_q;
  assign acc_wdata = (state == ST_IDLE) ? bus.wdata : wdata_q;
  assign acc_ok    = {1'b0, acc_addr} < DEPTH_W;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == ST_IDLE && bus.req) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (enter_resp && (!acc_ok || !acc_we)) begin
        rdata_q <= acc_ok ? mem[acc_addr] : '0;
      end
    end
  end

  // Contents survive reset; the clr_n gate keeps an aborted store from landing.
  always_ff @(posedge clk) begin
    if (clr_n && enter_resp && acc_we && acc_ok) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  assign bus.ready = (state == ST_RESP);
  assign bus.busy  = (state != ST_IDLE);
  assign bus.err   = (state == ST_RESP) && !({1'b0, addr_q} < DEPTH_W);
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench with reference model for three responder builds
module tb_dmem_responder;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  // unit 0: WAIT=2 DEPTH=64, unit 1: WAIT=2 DEPTH=48, unit 2: WAIT=0 DEPTH=64
  localparam int WT  [3] = '{2, 2, 0};
  localparam int DEP [3] = '{64, 48, 64};

  logic [2:0]  req_v;
  logic [2:0]  we_v;
  logic [5:0]  addr_v  [3];
  logic [31:0] wdata_v [3];
  wire  [2:0]  rdy_w;
  wire  [2:0]  err_w;
  wire  [2:0]  busy_w;
  wire  [31:0] rdata_w [3];

  dmem_responder_if #(.AW(6), .DW(32)) if_main ();
  dmem_responder_if #(.AW(6), .DW(32)) if_oor ();
  dmem_responder_if #(.AW(6), .DW(32)) if_w0 ();

  assign if_main.req = req_v[0];  assign if_main.we = we_v[0];
  assign if_main.addr = addr_v[0]; assign if_main.wdata = wdata_v[0];
  assign if_oor.req = req_v[1];   assign if_oor.we = we_v[1];
  assign if_oor.addr = addr_v[1];  assign if_oor.wdata = wdata_v[1];
  assign if_w0.req = req_v[2];    assign if_w0.we = we_v[2];
  assign if_w0.addr = addr_v[2];   assign if_w0.wdata = wdata_v[2];

  assign rdy_w  = {if_w0.ready, if_oor.ready, if_main.ready};
  assign err_w  = {if_w0.err, if_oor.err, if_main.err};
  assign busy_w = {if_w0.busy, if_oor.busy, if_main.busy};
  assign rdata_w[0] = if_main.rdata;
  assign rdata_w[1] = if_oor.rdata;
  assign rdata_w[2] = if_w0.rdata;

  dmem_responder #(.AW(6), .DW(32), .DEPTH(64), .WAIT(2)) u_main (.clk(clk), .clr_n(clr_n), .bus(if_main));
  dmem_responder #(.AW(6), .DW(32), .DEPTH(48), .WAIT(2)) u_oor  (.clk(clk), .clr_n(clr_n), .bus(if_oor));
  dmem_responder #(.AW(6), .DW(32), .DEPTH(64), .WAIT(0)) u_w0   (.clk(clk), .clr_n(clr_n), .bus(if_w0));

  logic [31:0] mdl  [3][64];
  logic [31:0] rd_m [3];
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 3; u++) rd_m[u] = '0;
  endtask

  // One request: accepted at edge 0, response expected in the cycle after edge WAIT.
  task automatic txn(input int u, input bit w, input logic [5:0] a, input logic [31:0] d);
    bit oor;
    oor = (int'(a) >= DEP[u]);
    if (oor) rd_m[u] = '0;
    else if (w) mdl[u][a] = d;
    else rd_m[u] = mdl[u][a];
    @(negedge clk);
    req_v[u] = 1'b1; we_v[u] = w; addr_v[u] = a; wdata_v[u] = d;
    @(posedge clk);
    @(negedge clk);
    req_v[u] = 1'b0; we_v[u] = 1'($urandom); addr_v[u] = 6'($urandom); wdata_v[u] = $urandom;
    for (int n = 0; n <= WT[u]; n++) begin
      if (n > 0) @(negedge clk);
      check("busy_txn", 32'(busy_w[u]), 32'd1);
      check("ready_txn", 32'(rdy_w[u]), (n == WT[u]) ? 32'd1 : 32'd0);
      if (n == WT[u]) begin
        check("err_txn", 32'(err_w[u]), 32'(oor));
        check("rdata_txn", rdata_w[u], rd_m[u]);
      end
    end
    @(negedge clk);
    check("busy_after", 32'(busy_w[u]), 32'd0);
    check("ready_after", 32'(rdy_w[u]), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [31:0] v1, v2;
    req_v = '0; we_v = '0;
    for (int u = 0; u < 3; u++) begin addr_v[u] = '0; wdata_v[u] = '0; end
    model_reset();
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check("reset_ready", 32'(rdy_w[u]), 32'd0);
      check("reset_busy", 32'(busy_w[u]), 32'd0);
      check("reset_rdata", rdata_w[u], 32'd0);
    end
    clr_n = 1'b1;

    for (int u = 0; u < 3; u++)
      for (int a = 0; a < DEP[u]; a++) txn(u, 1'b1, 6'(a), 32'h0);

    // Store then load at address 5
    txn(0, 1'b1, 6'd5, 32'hDEADBEEF);
    txn(0, 1'b0, 6'd5, 32'h0);

    // Out of range on the 48-word build; word 2 aliases 50 mod 48
    txn(1, 1'b1, 6'd2, 32'hA5A50002);
    txn(1, 1'b1, 6'd50, 32'h11112222);
    txn(1, 1'b0, 6'd50, 32'h0);
    txn(1, 1'b0, 6'd2, 32'h0);

    // Zero wait states
    txn(2, 1'b1, 6'd63, 32'hCAFEF00D);
    txn(2, 1'b0, 6'd63, 32'h0);

    // req held high: accepted at edges 0 and 4 only
    v1 = $urandom; v2 = $urandom;
    txn(0, 1'b1, 6'd1, v1);
    txn(0, 1'b1, 6'd2, v2);
    pulses = 0;
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 6'd1;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) addr_v[0] = 6'd2;
      if (rdy_w[0]) pulses++;
      check("held_ready", 32'(rdy_w[0]), (c == 2 || c == 6) ? 32'd1 : 32'd0);
      if (c == 2) check("held_rdata1", rdata_w[0], v1);
      if (c == 6) begin
        check("held_rdata2", rdata_w[0], v2);
        req_v[0] = 1'b0;
      end
    end
    check("held_pulses", 32'(pulses), 32'd2);
    rd_m[0] = v2;

    // A short req pulse while busy is neither queued nor sticky
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 6'd1;
    @(posedge clk);
    @(negedge clk);
    pulses = 0;
    addr_v[0] = 6'd2;
    for (int c = 1; c < 9; c++) begin
      @(negedge clk);
      if (c == 2) req_v[0] = 1'b0;
      if (rdy_w[0]) pulses++;
    end
    check("busy_req_pulses", 32'(pulses), 32'd1);
    check("busy_req_rdata", rdata_w[0], v1);
    rd_m[0] = v1;

    // Asynchronous reset with ready high and rdata non-zero
    txn(0, 1'b1, 6'd9, 32'h5A5A5A5A);
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 6'd9;
    @(posedge clk);
    @(negedge clk); req_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_ready", 32'(rdy_w[0]), 32'd1);
    check("pre_reset_rdata", rdata_w[0], 32'h5A5A5A5A);
    #1 clr_n = 1'b0;
    #1;
    check("async_ready", 32'(rdy_w[0]), 32'd0);
    check("async_busy", 32'(busy_w[0]), 32'd0);
    check("async_err", 32'(err_w[0]), 32'd0);
    check("async_rdata", rdata_w[0], 32'd0);
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;

    // Reset in WAIT aborts a store
    txn(0, 1'b1, 6'd7, 32'h0);
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 6'd7; wdata_v[0] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_v[0] = 1'b0;
    check("abort_busy", 32'(busy_w[0]), 32'd1);
    clr_n = 1'b0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rdy_w[0]) pulses++;
    end
    clr_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rdy_w[0]) pulses++;
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    model_reset();
    txn(0, 1'b0, 6'd7, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      int u;
      u = (i % 3 == 2) ? 2 : ((i % 3 == 1) ? 1 : 0);
      txn(u, 1'($urandom), 6'($urandom), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder that serves the processor's load/store requests over a req/ready handshake with a fixed, parameterised number of wait states. It is the memory side of the processor's data-memory port: it latches one request, models access latency, then commits the write or returns the read word. It lets the core be exercised against a slow memory instead of the zero-latency data memory.

## Interface
- AW, 6, word-address width
- DW, 32, data word width
- DEPTH, 64, implemented words; valid addresses are 0..DEPTH-1, and DEPTH ≤ 2^AW
- WAIT, 2, wait states inserted before the response; 0 is legal
- clk  in  1  clock; all state changes on the rising edge
- clr_n  in  1  asynchronous active-low reset
- req  in  1  request strobe from the initiator
- we  in  1  1 = store, 0 = load; sampled with req
- addr  in  AW  word address; sampled with req
- wdata  in  DW  store data; sampled with req
- ready  out  1  one-cycle response strobe
- rdata  out  DW  load data; valid when ready=1 for a load
- err  out  1  address error flag; valid when ready=1
- busy  out  1  high whenever a request is outstanding

## Operation
- FSM states:
  - IDLE: the only state in which req is sampled.
  - WAIT: counts down wait states.
  - RESP: drives the response for one cycle.
- IDLE, req=1 at an edge: latch we, addr and wdata into internal registers. The initiator's inputs are don't-care after that edge.
  - If WAIT=0, go to RESP.
  - Otherwise go to WAIT with cnt=WAIT-1.
- WAIT: if cnt=0, go to RESP; otherwise cnt decrements.
- Transition into RESP performs the access on the latched values:
  - Store with addr_q<DEPTH: RAM[addr_q] ← wdata_q. rdata is unchanged.
  - Load with addr_q<DEPTH: rdata ← RAM[addr_q].
  - addr_q≥DEPTH: no RAM write; rdata ← 0; err ← 1.
- RESP lasts exactly one cycle with ready=1, then the FSM returns to IDLE unconditionally. req is ignored while in RESP.
- busy=1 in WAIT and RESP, 0 in IDLE. busy is decoded from registered state, with no combinational path from req.
- rdata holds its last value until the next load response or reset. Store responses do not alter rdata.
- err is 0 outside RESP. In RESP it is 1 only for an out-of-range address.
- RAM contents are not cleared by reset. Simulation initial contents are X unless the bench preloads them hierarchically through the RAM array.
- A load issued after a store's ready returns the stored data; there is no forwarding hazard.
- A new req while busy=1 is ignored. It is not queued and not sticky.

## Timing
- Number the acceptance edge 0.
  - ready is high in the cycle following edge WAIT, and low elsewhere.
  - Load-to-data latency is WAIT+1 cycles.
- Minimum request spacing is WAIT+2 cycles:
  - An initiator that holds req high continuously is accepted at edges 0, WAIT+2, 2(WAIT+2), and so on.
  - An initiator must drop req in the ready cycle to avoid a repeat request.
- Reset (clr_n=0), asynchronous and effective immediately: state=IDLE, cnt=0, ready=0, err=0, busy=0, rdata=0, latched request registers cleared.
- Reset during WAIT or RESP aborts the transaction. A store that has not yet entered RESP is never committed.
- Reset deassertion is assumed synchronous to clk by the system. The first request can be accepted at the first edge with clr_n=1.
- WAIT=0 case: the acceptance edge enters RESP directly, so ready is high in the next cycle. Spacing is 2 cycles.

## Test plan
- Reset with outputs forced: drive clr_n=0 mid-cycle → ready, err, busy and rdata go to 0 immediately, without a clock edge.
- Store then load, WAIT=2:
  - Store addr=5, wdata=0xDEADBEEF at edge 0 → ready in the cycle after edge 2, busy high for 3 cycles.
  - Load addr=5 → rdata=0xDEADBEEF with ready 3 cycles after acceptance, err=0.
- Back-to-back with req held high:
  - Loads to addresses 1 and 2 are accepted at edges 0 and 4.
  - Exactly two ready pulses occur.
  - A req asserted during busy is dropped.
- Out of range, DEPTH=48: store to 50 then load from 50 → both responses have err=1, the load returns rdata=0, and RAM[50 mod 48] is unchanged.
- Reset mid-transaction: store 0x12345678 to addr 7 (previously 0x0), assert clr_n=0 during WAIT, release, load addr 7 → returns 0x0 and no ready pulse occurs for the aborted store.
- WAIT=0 build: store then load to addr 63 → each ready arrives 1 cycle after acceptance and the load returns the stored value.
